// File: rtl/mult_seq_parity_pkg.sv
// Shared definitions for the parity-checked sequential signed multiplier.
// Holds widths, the shift-add iteration count, the FSM state encoding,
// the result payload struct and the operand magnitude helper.
package mult_seq_parity_pkg;

  localparam int unsigned OP_W       = 16;
  localparam int unsigned RES_W      = 32;
  localparam int unsigned MAG_W      = OP_W + 1;
  localparam int unsigned MULT_ITER  = 16;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    SIGN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Result payload as presented while result_rdy is high.
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             result_parity;
    logic             arg_parity_error;
  } result_t;

  // 17-bit magnitude so that -32768 maps to +32768 without overflow.
  function automatic logic [MAG_W-1:0] mag_of(input logic [OP_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[OP_W-1], v};
    return v[OP_W-1] ? MAG_W'(-ext) : ext;
  endfunction

endpackage

// File: rtl/mult_seq_parity_parity_gen.sv
// Even-parity generator: XOR reduction of a W-bit word.
// Ports:
//   i_data      W-bit input word
//   o_parity_c  combinational XOR of all i_data bits
module parity_gen #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_data,
  output logic         o_parity_c
);

  assign o_parity_c = ^i_data;

endmodule

// File: rtl/mult_seq_parity.sv
// Sequential 16x16 signed multiplier with operand parity checking.
// A 0->1 edge on req in IDLE captures the operands; CHECK verifies parity,
// MULT runs a 16-step shift-add on magnitudes, SIGN fixes the sign and
// computes result parity, DONE hands the result out.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req                  transaction request (rising edge starts)
//   arg_a/arg_b          signed 16-bit operands
//   arg_a/b_parity       even-parity bits of the operands
//   ack                  one-cycle pulse in the CHECK cycle
//   result               signed 32-bit product (0 on parity error)
//   result_parity        XOR of result bits
//   arg_parity_error     operand parity mismatch flag
//   result_rdy           one-cycle pulse, result fields valid while high
module mult_seq_parity
  import mult_seq_parity_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [OP_W-1:0]  arg_a,
  input  logic             arg_a_parity,
  input  logic [OP_W-1:0]  arg_b,
  input  logic             arg_b_parity,
  output logic             ack,
  output logic [RES_W-1:0] result,
  output logic             result_parity,
  output logic             arg_parity_error,
  output logic             result_rdy
);

  state_t             r_state;
  logic               r_req_prev;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic               r_a_par;
  logic               r_b_par;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_mcand;
  logic [MAG_W-1:0]   r_mplier;
  logic [RES_W-1:0]   r_acc;
  logic               r_neg;
  logic               r_err_pend;

  logic               w_start;
  logic               w_par_a;
  logic               w_par_b;
  logic               w_par_err;
  logic [MAG_W-1:0]   w_mag_a;
  logic [MAG_W-1:0]   w_mag_b;
  logic [RES_W-1:0]   w_signed;
  logic               w_res_par;

  assign w_start   = req & ~r_req_prev;
  assign w_par_err = (w_par_a != r_a_par) | (w_par_b != r_b_par);
  assign w_mag_a   = mag_of(r_a);
  assign w_mag_b   = mag_of(r_b);
  assign w_signed  = r_neg ? RES_W'(-r_acc) : r_acc;

  parity_gen #(.W(OP_W)) u_par_a (
    .i_data     (r_a),
    .o_parity_c (w_par_a)
  );

  parity_gen #(.W(OP_W)) u_par_b (
    .i_data     (r_b),
    .o_parity_c (w_par_b)
  );

  parity_gen #(.W(RES_W)) u_par_res (
    .i_data     (w_signed),
    .o_parity_c (w_res_par)
  );

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_req_prev       <= 1'b0;
      r_a              <= '0;
      r_b              <= '0;
      r_a_par          <= 1'b0;
      r_b_par          <= 1'b0;
      r_cnt            <= '0;
      r_mcand          <= '0;
      r_mplier         <= '0;
      r_acc            <= '0;
      r_neg            <= 1'b0;
      r_err_pend       <= 1'b0;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      result_rdy       <= 1'b0;
    end else begin
      r_req_prev <= req;
      ack        <= 1'b0;
      result_rdy <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_a     <= arg_a;
            r_b     <= arg_b;
            r_a_par <= arg_a_parity;
            r_b_par <= arg_b_parity;
            ack     <= 1'b1;
            r_state <= CHECK;
          end
        end

        CHECK: begin
          if (w_par_err) begin
            r_err_pend <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_mcand  <= RES_W'(w_mag_a);
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= r_a[OP_W-1] ^ r_b[OP_W-1];
            r_state  <= MULT;
          end
        end

        // One multiplier bit per cycle, LSB first.
        MULT: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= {r_mcand[RES_W-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[MAG_W-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MULT_ITER - 1)) begin
            r_state <= SIGN;
          end
        end

        // Signed result is published on entry to DONE.
        SIGN: begin
          result           <= w_signed;
          result_parity    <= w_res_par;
          arg_parity_error <= 1'b0;
          result_rdy       <= 1'b1;
          r_state          <= DONE;
        end

        // Error results are published on the DONE exit edge, giving the
        // parity-error path its two-edge latency after capture.
        DONE: begin
          if (r_err_pend) begin
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b1;
            result_rdy       <= 1'b1;
          end
          r_err_pend <= 1'b0;
          r_state    <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_parity.sv
// Scoreboard bench for mult_seq_parity: stimulus pushes expected results,
// a negedge monitor pops and compares whenever result_rdy is high.
module tb_mult_seq_parity;
  import mult_seq_parity_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             req;
  logic [OP_W-1:0]  arg_a;
  logic             arg_a_parity;
  logic [OP_W-1:0]  arg_b;
  logic             arg_b_parity;
  logic             ack;
  logic [RES_W-1:0] result;
  logic             result_parity;
  logic             arg_parity_error;
  logic             result_rdy;

  result_t sb[$];
  int total = 0;
  int bad   = 0;

  mult_seq_parity dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .result_rdy       (result_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every result_rdy pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (result_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy actual=%h required=no_pulse", result);
      end else begin
        result_t e;
        e = sb.pop_front();
        chk("result", result, e.result);
        chk("result_parity", 32'(result_parity), 32'(e.result_parity));
        chk("arg_parity_error", 32'(arg_parity_error), 32'(e.arg_parity_error));
      end
    end
  end

  // One transaction: push expectation, raise req, check ack count and latency.
  task automatic run_txn(input logic [15:0] a, input logic ap,
                         input logic [15:0] b, input logic bp,
                         input logic [31:0] exp_res, input logic exp_par,
                         input logic exp_err, input int exp_lat,
                         input bit pulse_e5, input bit pre_low);
    int acks;
    int lat;
    if (pre_low) begin
      req = 1'b0;
      @(negedge clk);
    end
    sb.push_back('{result: exp_res, result_parity: exp_par, arg_parity_error: exp_err});
    arg_a = a; arg_a_parity = ap;
    arg_b = b; arg_b_parity = bp;
    req = 1'b1;
    acks = 0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
      if (k == 0) req = 1'b0;
      if (pulse_e5 && k == 4) req = 1'b1;
      if (pulse_e5 && k == 5) req = 1'b0;
      if (result_rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("ack_count", 32'(acks), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0;
    arg_a = '0; arg_a_parity = 1'b0; arg_b = '0; arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdy", 32'(result_rdy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_err", 32'(arg_parity_error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 * -5 = -15
    run_txn(16'd3, 1'b0, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 18, 1'b0, 1'b1);
    // -32768 * -32768
    run_txn(16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b1, 1'b0, 18, 1'b0, 1'b1);
    // -32768 * 1
    run_txn(16'h8000, 1'b1, 16'h0001, 1'b1, 32'hFFFF_8000, 1'b1, 1'b0, 18, 1'b0, 1'b1);
    // wrong parity on arg_a
    run_txn(16'd7, 1'b0, 16'd2, 1'b1, 32'h0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    // extra req edge at E5 ignored: 100 * 200 = 20000
    run_txn(16'd100, 1'b1, 16'd200, 1'b1, 32'h0000_4E20, 1'b1, 1'b0, 18, 1'b1, 1'b1);
    repeat (25) @(negedge clk);
    chk("hold_result", result, 32'h0000_4E20);

    // Abort at E10, req held through reset release restarts on first edge.
    req = 1'b0;
    @(negedge clk);
    arg_a = 16'd5; arg_a_parity = 1'b0; arg_b = 16'd6; arg_b_parity = 1'b0;
    req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
    end
    rst_n = 1'b0;
    req = 1'b1;
    #1;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_rdy", 32'(result_rdy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_parity", 32'(result_parity), 32'd0);
    chk("abort_err", 32'(arg_parity_error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // -3 * -4 = 12
    run_txn(16'hFFFD, 1'b1, 16'hFFFC, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 18, 1'b0, 1'b0);

    // Back-to-back: 0 * -1, then 32767 * 32767
    run_txn(16'd0, 1'b0, 16'hFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 18, 1'b0, 1'b1);
    run_txn(16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b1, 1'b0, 18, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("hold_last", result, 32'h3FFF_0001);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_parity.md
MULT_SEQ_PARITY -- requirements
Module: mult_seq_parity

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, result width at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  operation request; a transaction starts on a sampled 0->1 transition.
REQ-005 arg_a  input  16  signed operand A, two's complement.
REQ-006 arg_a_parity  input  1  even-parity bit for arg_a, equal to the XOR of all arg_a bits.
REQ-007 arg_b  input  16  signed operand B.
REQ-008 arg_b_parity  input  1  even-parity bit for arg_b.
REQ-009 ack  output  1  one-cycle pulse confirming operands captured.
REQ-010 result  output  32  signed product, or 0 on parity error.
REQ-011 result_parity  output  1  XOR of all 32 result bits.
REQ-012 arg_parity_error  output  1  set when either operand parity mismatches.
REQ-013 result_rdy  output  1  one-cycle pulse; result, result_parity and arg_parity_error are valid while it is high.

Function
REQ-014 Register req into req_prev every cycle; a start is (req==1 && req_prev==0) sampled while in IDLE.
REQ-015 FSM states SHALL be IDLE, CHECK, MULT, SIGN and DONE.
REQ-016 IDLE->CHECK on a start; arg_a, arg_b and both parity bits are latched on that same edge.
REQ-017 ack SHALL be 1 exactly during the CHECK cycle.
REQ-018 CHECK SHALL compute parity on the latched operands:
- any mismatch -> DONE, with result=0, result_parity=0, arg_parity_error=1.
- no mismatch -> MULT, with arg_parity_error=0.
REQ-019 MULT SHALL be an iterative shift-add on 17-bit operand magnitudes, one bit per cycle, exactly 16 cycles, counted by a 5-bit counter.
REQ-020 SIGN (1 cycle): negate the 32-bit magnitude if the operand signs differ; compute result_parity.
REQ-021 DONE (1 cycle): result_rdy=1; next state IDLE.
REQ-022 Latency, counted from the start-sampling edge E0:
- result_rdy is high in the cycle after edge E18 on the valid path.
- result_rdy is high in the cycle after edge E2 on the error path.
REQ-023 Product SHALL be exact for all inputs; -32768*-32768 = 32'sh4000_0000; -32768*1 = 32'shFFFF_8000.
REQ-024 result, result_parity and arg_parity_error SHALL hold their last values until the next DONE.
REQ-025 A req rising edge outside IDLE SHALL be ignored; req_prev still tracks, so a new start requires a fresh 0->1 edge after return to IDLE.
REQ-026 Results SHALL be produced strictly in request order, with at most one transaction in flight.

Reset
REQ-027 While rst_n=0:
- state=IDLE and req_prev=0.
- ack=0 and result_rdy=0.
- result=0, result_parity=0, arg_parity_error=0.
- counter and datapath registers are cleared.
REQ-028 Reset asserted mid-operation SHALL abort the transaction with no result_rdy pulse.
REQ-029 A req held high through reset release SHALL count as a start on the first post-reset edge.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, operand/result width constants and the MULT iteration count; the scoreboard and BFM use the same package.
REQ-031 Parity generation SHALL be a single sub-module, parity_gen, parameterised by width and instantiated for 16-bit and 32-bit checks.

Verification
REQ-032 Directed scenarios:
- arg_a=3, arg_b=-5, correct parities -> ack once, then result_rdy after E18 with result=-15, result_parity=1, arg_parity_error=0.
- arg_a=16'h8000, arg_b=16'h8000, parities 1,1 -> result=32'h4000_0000, result_parity=1.
- arg_a=7, arg_a_parity=0 (wrong), arg_b=2 -> result_rdy after E2 with result=0, arg_parity_error=1.
- req pulsed again at E5 of a transaction -> ignored; exactly one result_rdy.
- rst_n low at E10 of a transaction -> all outputs 0, no result_rdy; a new req after release gives the correct product.
- Back-to-back transactions (0*-1, 32767*32767) -> results 0 then 32'h3FFF_0001, delivered in order.
